// File: rtl/block_interleaver_pkg.sv
// -----------------------------------------------------------------------------
// interleaver_pkg
// Shared constants and helpers for the bit-serial row/column block interleaver.
//   ROWS_DEFAULT / COLS_DEFAULT : default matrix geometry
//   BLOCK_BITS                  : bits per block at the default geometry
//   ctr_width()                 : width of a counter spanning 0..extent-1,
//                                 never less than one bit
// -----------------------------------------------------------------------------
package interleaver_pkg;

    localparam int ROWS_DEFAULT = 4;
    localparam int COLS_DEFAULT = 8;
    localparam int BLOCK_BITS   = ROWS_DEFAULT * COLS_DEFAULT;

    // Counter width for an index range of 'extent' values (minimum 1 bit).
    function automatic int ctr_width(input int extent);
        return (extent <= 2) ? 1 : $clog2(extent);
    endfunction

endpackage

// File: rtl/block_interleaver_if.sv
// -----------------------------------------------------------------------------
// block_interleaver_if
// Groups the upstream and downstream bit-stream handshakes of the interleaver.
//   in_valid / in_bit / in_ready              : upstream bit stream
//   out_valid / out_bit / out_ready / out_last : downstream bit stream
// Modports:
//   slave  : the interleaver's view (consumes in_*, produces out_*)
//   master : the environment's view (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface block_interleaver_if;

    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_valid;
    logic out_bit;
    logic out_ready;
    logic out_last;

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

endinterface

// File: rtl/block_interleaver_rc_counter.sv
// -----------------------------------------------------------------------------
// interleave_rc_counter
// Two-level index counter: the inner index advances on every enable, wraps at
// INNER-1 and carries into the outer index, which wraps at OUTER-1. 'last' is
// high while both indices sit at their final value, so the enable that
// consumes the last position returns both indices to zero.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset, clears both indices
//   en        : advance by one position
//   inner_idx : fast-moving index (0..INNER-1)
//   outer_idx : slow-moving index (0..OUTER-1)
//   last      : both indices at their maximum
// -----------------------------------------------------------------------------
module interleave_rc_counter
    import interleaver_pkg::*;
#(
    parameter int INNER = 8,
    parameter int OUTER = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    output logic [ctr_width(INNER)-1:0]  inner_idx,
    output logic [ctr_width(OUTER)-1:0]  outer_idx,
    output logic                         last
);

    localparam int IW = ctr_width(INNER);
    localparam int OW = ctr_width(OUTER);
    localparam logic [IW-1:0] INNER_MAX = IW'(INNER - 1);
    localparam logic [OW-1:0] OUTER_MAX = OW'(OUTER - 1);

    logic [IW-1:0] inner_r;
    logic [OW-1:0] outer_r;
    logic          inner_wrap_s;
    logic          outer_wrap_s;

    assign inner_wrap_s = (inner_r == INNER_MAX);
    assign outer_wrap_s = (outer_r == OUTER_MAX);

    // Index registers: inner counts every enable, outer counts on inner wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inner_r <= '0;
            outer_r <= '0;
        end else if (en) begin
            if (inner_wrap_s) begin
                inner_r <= '0;
                outer_r <= outer_wrap_s ? '0 : outer_r + OW'(1);
            end else begin
                inner_r <= inner_r + IW'(1);
                outer_r <= outer_r;
            end
        end else begin
            inner_r <= inner_r;
            outer_r <= outer_r;
        end
    end

    assign inner_idx = inner_r;
    assign outer_idx = outer_r;
    assign last      = inner_wrap_s && outer_wrap_s;

endmodule

// File: rtl/block_interleaver.sv
// -----------------------------------------------------------------------------
// block_interleaver
// Bit-serial row/column block interleaver with ping-pong storage. Bits are
// written row-major into a ROWS x COLS matrix and read column-major, so input
// index row*COLS+col leaves at output position col*ROWS+row. While one bank
// drains, the other fills, giving 1 bit/clock in steady state.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset; discards partial and pending blocks
//   bus   : slave modport of block_interleaver_if
//           in_valid/in_bit/in_ready               upstream handshake
//           out_valid/out_bit/out_ready/out_last   downstream handshake,
//           out_last marks the final bit of each output block
// -----------------------------------------------------------------------------
module block_interleaver
    import interleaver_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    block_interleaver_if.slave   bus
);

    localparam int NBITS = ROWS * COLS;
    localparam int AW    = $clog2(NBITS);
    localparam int RW    = ctr_width(ROWS);
    localparam int CW    = ctr_width(COLS);

    // Bank contents need no reset: a bank is only read once its full flag,
    // which is reset, says it has been completely rewritten.
    logic [NBITS-1:0] bank_r [2];
    logic [1:0]       full_r;
    logic [1:0]       full_next_s;
    logic [1:0]       full_set_s;
    logic [1:0]       full_clr_s;
    logic             wb_r;
    logic             rb_r;

    logic [RW-1:0]    w_row_s;
    logic [CW-1:0]    w_col_s;
    logic [RW-1:0]    r_row_s;
    logic [CW-1:0]    r_col_s;
    logic             w_last_s;
    logic             r_last_s;
    logic [AW-1:0]    w_addr_s;
    logic [AW-1:0]    r_addr_s;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             wr_hs_s;
    logic             rd_hs_s;
    logic             wr_done_s;
    logic             rd_done_s;

    // Handshake qualifiers are forced low while reset is asserted.
    assign in_ready_s  = reset && !full_r[wb_r];
    assign out_valid_s = reset &&  full_r[rb_r];
    assign wr_hs_s     = bus.in_valid && in_ready_s;
    assign rd_hs_s     = out_valid_s && bus.out_ready;
    assign wr_done_s   = wr_hs_s && w_last_s;
    assign rd_done_s   = rd_hs_s && r_last_s;

    // Write side walks row-major: column is the inner index.
    interleave_rc_counter #(
        .INNER (COLS),
        .OUTER (ROWS)
    ) u_wr_ctr (
        .clk       (clk),
        .reset     (reset),
        .en        (wr_hs_s),
        .inner_idx (w_col_s),
        .outer_idx (w_row_s),
        .last      (w_last_s)
    );

    // Read side walks column-major: row is the inner index.
    interleave_rc_counter #(
        .INNER (ROWS),
        .OUTER (COLS)
    ) u_rd_ctr (
        .clk       (clk),
        .reset     (reset),
        .en        (rd_hs_s),
        .inner_idx (r_row_s),
        .outer_idx (r_col_s),
        .last      (r_last_s)
    );

    assign w_addr_s = AW'(w_row_s) * AW'(COLS) + AW'(w_col_s);
    assign r_addr_s = AW'(r_row_s) * AW'(COLS) + AW'(r_col_s);

    // Completing a write and completing a read always touch different banks,
    // so the set and clear masks never overlap.
    assign full_set_s  = {wr_done_s &  wb_r, wr_done_s & ~wb_r};
    assign full_clr_s  = {rd_done_s &  rb_r, rd_done_s & ~rb_r};
    assign full_next_s = (full_r | full_set_s) & ~full_clr_s;

    // Bank storage: capture the accepted bit at its row-major position.
    always_ff @(posedge clk) begin
        if (wr_hs_s) begin
            bank_r[wb_r][w_addr_s] <= bus.in_bit;
        end else begin
            bank_r[wb_r] <= bank_r[wb_r];
        end
    end

    // Bank ownership: full flags and write/read bank pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full_r <= 2'b00;
            wb_r   <= 1'b0;
            rb_r   <= 1'b0;
        end else begin
            full_r <= full_next_s;
            wb_r   <= wb_r ^ wr_done_s;
            rb_r   <= rb_r ^ rd_done_s;
        end
    end

    // All outputs derive from registered state, so they hold while stalled.
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_bit   = bank_r[rb_r][r_addr_s];
    assign bus.out_last  = out_valid_s && r_last_s;

endmodule

// File: tb/tb_block_interleaver.sv
// -----------------------------------------------------------------------------
// tb_block_interleaver
// Directed bench for block_interleaver: a 4x8 instance and a 3x5 instance.
// -----------------------------------------------------------------------------
module tb_block_interleaver;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    block_interleaver_if bi_if ();
    block_interleaver_if bs_if ();

    block_interleaver #(.ROWS(4), .COLS(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi_if.slave)
    );

    block_interleaver #(.ROWS(3), .COLS(5)) u_dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bs_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference column-major readout of a 4x8 row-major block.
    function automatic logic [31:0] interleave_ref(input logic [31:0] blk);
        logic [31:0] r;
        for (int p = 0; p < 32; p++) r[p] = blk[(p % 4) * 8 + p / 4];
        return r;
    endfunction

    // Feed n bits (bit i = data[i]); called and returns 1 time unit after a posedge.
    task automatic feed(input bit sm, input int n, input logic [95:0] data, input int budget,
                        output int stalls, output int vcount);
        int  i;
        int  cyc;
        logic rdy;
        i = 0; cyc = 0; stalls = 0; vcount = 0;
        while (i < n && cyc < budget) begin
            if (sm) begin bs_if.in_valid = 1'b1; bs_if.in_bit = data[i]; end
            else    begin bi_if.in_valid = 1'b1; bi_if.in_bit = data[i]; end
            @(negedge clk);
            rdy = sm ? bs_if.in_ready : bi_if.in_ready;
            if (rdy) i++;
            else stalls++;
            if ((sm ? bs_if.out_valid : bi_if.out_valid) === 1'b1) vcount++;
            @(posedge clk); #1;
            cyc++;
        end
        bi_if.in_valid = 1'b0;
        bs_if.in_valid = 1'b0;
        if (i < n) check("feed_timeout", 96'(i), 96'(n));
    endtask

    // Collect n output bits with out_ready held high.
    task automatic collect(input bit sm, input int n, input int budget,
                           output logic [95:0] bits, output logic [95:0] lasts,
                           output int first, output int gaps);
        int   j;
        int   cyc;
        logic v;
        j = 0; cyc = 0; first = -1; gaps = 0; bits = '0; lasts = '0;
        if (sm) bs_if.out_ready = 1'b1; else bi_if.out_ready = 1'b1;
        while (j < n && cyc < budget) begin
            @(negedge clk);
            v = sm ? bs_if.out_valid : bi_if.out_valid;
            if (v === 1'b1) begin
                if (first < 0) first = cyc;
                bits[j]  = sm ? bs_if.out_bit  : bi_if.out_bit;
                lasts[j] = sm ? bs_if.out_last : bi_if.out_last;
                j++;
            end else if (first >= 0) begin
                gaps++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bi_if.out_ready = 1'b0;
        bs_if.out_ready = 1'b0;
        if (j < n) check("collect_timeout", 96'(j), 96'(n));
    endtask

    initial begin
        logic [95:0] pat;
        logic [95:0] bits;
        logic [95:0] lasts;
        logic [95:0] got;
        int stalls, vcount, first, gaps;
        int acc, diffs, ready_cyc, last_cyc, j;
        logic snap_v, snap_b, snap_l;

        n_checks = 0;
        n_errors = 0;
        bi_if.in_valid = 1'b1; bi_if.in_bit = 1'b1; bi_if.out_ready = 1'b0;
        bs_if.in_valid = 1'b0; bs_if.in_bit = 1'b0; bs_if.out_ready = 1'b0;
        reset = 1'b0;

        // Reset held low with in_valid asserted.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_in_ready",  96'(bi_if.in_ready),  96'd0);
            check("rst_out_valid", 96'(bi_if.out_valid), 96'd0);
            check("rst_out_last",  96'(bi_if.out_last),  96'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bi_if.in_valid = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 96'(bi_if.in_ready), 96'd1);
        @(posedge clk); #1;

        // One-hot mapping on the 4x8 instance.
        feed(0, 32, 96'h2, 100, stalls, vcount);
        collect(0, 32, 100, bits, lasts, first, gaps);
        check("onehot_idx1", bits[31:0], 96'h10);
        check("onehot_idx1_last", lasts[31:0], 96'h8000_0000);
        feed(0, 32, 96'h200, 100, stalls, vcount);
        collect(0, 32, 100, bits, lasts, first, gaps);
        check("onehot_idx9", bits[31:0], 96'h20);
        check("onehot_idx9_last", lasts[31:0], 96'h8000_0000);
        feed(0, 32, 96'h100, 100, stalls, vcount);
        collect(0, 32, 100, bits, lasts, first, gaps);
        check("onehot_idx8", bits[31:0], 96'h2);
        check("onehot_idx8_last", lasts[31:0], 96'h8000_0000);

        // Streaming: 96 bits of a byte-counter pattern, ready held high.
        pat = 96'h0B0A_0908_0706_0504_0302_0100;
        fork
            feed(0, 96, pat, 300, stalls, vcount);
            collect(0, 96, 300, bits, lasts, first, gaps);
        join
        check("stream_stalls", 96'(stalls), 96'd0);
        check("stream_first_valid", 96'(first), 96'd32);
        check("stream_gaps", 96'(gaps), 96'd0);
        for (int m = 0; m < 3; m++)
            check($sformatf("stream_blk%0d", m), bits[32*m +: 32], interleave_ref(pat[32*m +: 32]));
        check("stream_last", lasts, {3{32'h8000_0000}});

        // Backpressure: downstream stalled, upstream always valid.
        pat = 96'h0000_0000_C3A5_5A3C_F00F_9617;
        acc = 0; diffs = 0;
        snap_v = 1'b0; snap_b = 1'b0; snap_l = 1'b0;
        for (int c = 0; c < 80; c++) begin
            bi_if.in_valid = 1'b1;
            bi_if.in_bit   = pat[acc];
            @(negedge clk);
            if (bi_if.in_ready === 1'b1) acc++;
            if (c == 32) begin
                snap_v = bi_if.out_valid; snap_b = bi_if.out_bit; snap_l = bi_if.out_last;
            end else if (c > 32) begin
                if (bi_if.out_valid !== snap_v || bi_if.out_bit !== snap_b ||
                    bi_if.out_last !== snap_l) diffs++;
            end
            @(posedge clk); #1;
        end
        bi_if.in_valid = 1'b0;
        check("bp_accepted", 96'(acc), 96'd64);
        check("bp_valid_held", 96'(snap_v), 96'd1);
        check("bp_stable", 96'(diffs), 96'd0);

        // Release backpressure and drain both banks.
        j = 0; ready_cyc = -1; last_cyc = -1; got = '0;
        bi_if.out_ready = 1'b1;
        for (int c = 0; c < 100 && j < 64; c++) begin
            @(negedge clk);
            if (bi_if.in_ready === 1'b1 && ready_cyc < 0) ready_cyc = c;
            if (bi_if.out_valid === 1'b1) begin
                got[j] = bi_if.out_bit;
                if (bi_if.out_last === 1'b1 && last_cyc < 0) last_cyc = c;
                j++;
            end
            @(posedge clk); #1;
        end
        bi_if.out_ready = 1'b0;
        check("bp_drained", 96'(j), 96'd64);
        check("bp_first_last_cyc", 96'(last_cyc), 96'd31);
        check("bp_ready_return", 96'(ready_cyc), 96'(last_cyc + 1));
        check("bp_blk0", got[31:0],  interleave_ref(pat[31:0]));
        check("bp_blk1", got[63:32], interleave_ref(pat[63:32]));

        // Mid-block reset discards a partial block.
        feed(0, 10, {96{1'b1}}, 50, stalls, vcount);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        feed(0, 32, 96'h4, 100, stalls, vcount);
        check("mr_no_early_valid", 96'(vcount), 96'd0);
        collect(0, 32, 100, bits, lasts, first, gaps);
        check("mr_data", bits[31:0], 96'h100);
        check("mr_last", lasts[31:0], 96'h8000_0000);
        @(negedge clk);
        check("mr_empty_after", 96'(bi_if.out_valid), 96'd0);
        @(posedge clk); #1;

        // 3x5 geometry: row 0 set, then index 13 alone.
        feed(1, 15, 96'h001F, 60, stalls, vcount);
        collect(1, 15, 60, bits, lasts, first, gaps);
        check("small_row0", bits[14:0], 96'h1249);
        check("small_row0_last", lasts[14:0], 96'h4000);
        feed(1, 15, 96'h2000, 60, stalls, vcount);
        collect(1, 15, 60, bits, lasts, first, gaps);
        check("small_idx13", bits[14:0], 96'h0800);
        check("small_idx13_last", lasts[14:0], 96'h4000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
